// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod: count controls in, count and cascade outputs back.
interface updown_counter_mod_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] nQ;
    logic             tc;
    logic             wrap;

    modport master (output en, up, load, d, input Q, nQ, tc, wrap);
    modport slave  (input en, up, load, d, output Q, nQ, tc, wrap);
endinterface

// File: rtl/updown_counter_mod.sv
// Synchronous modulo up/down counter with clamped parallel load, wrap/saturate mode
// and combinational terminal count for en/tc cascading.
module updown_counter_mod #(
    parameter int WIDTH    = 3,
    parameter int MODULO   = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    updown_counter_mod_if.slave bus
);

    if (WIDTH < 1 || MODULO < 2 || (WIDTH < 31 && MODULO > (1 << WIDTH))) begin : g_bad_param
        $error("updown_counter_mod: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] q_eff;

    always_comb begin
        // An out-of-range count behaves as the top of the range on the next count.
        q_eff  = (q_q > MAX_Q) ? MAX_Q : q_q;
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d = (bus.d > MAX_Q) ? MAX_Q : bus.d;
        end else if (bus.en) begin
            if (bus.up) begin
                if (q_eff == MAX_Q) begin
                    q_d    = SATURATE ? MAX_Q : '0;
                    wrap_d = ~SATURATE;
                end else begin
                    q_d = q_eff + WIDTH'(1);
                end
            end else begin
                if (q_eff == '0) begin
                    q_d    = SATURATE ? '0 : MAX_Q;
                    wrap_d = ~SATURATE;
                end else begin
                    q_d = q_eff - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.nQ   = ~q_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.en & ((bus.up & (q_q == MAX_Q)) | (~bus.up & (q_q == '0)));

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: three 3-bit counters (mod 8 wrap, mod 6 wrap, mod 8 saturate) and a
// two-stage mod-10 cascade, all checked against an arithmetic reference model.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, ld;
    logic [2:0] d3;
    logic [3:0] dl, dh;

    always #5 clk = ~clk;

    updown_counter_mod_if #(.WIDTH(3)) a_if ();
    updown_counter_mod_if #(.WIDTH(3)) b_if ();
    updown_counter_mod_if #(.WIDTH(3)) c_if ();
    updown_counter_mod_if #(.WIDTH(4)) l_if ();
    updown_counter_mod_if #(.WIDTH(4)) h_if ();

    assign a_if.en = en;  assign a_if.up = up;  assign a_if.load = ld;  assign a_if.d = d3;
    assign b_if.en = en;  assign b_if.up = up;  assign b_if.load = ld;  assign b_if.d = d3;
    assign c_if.en = en;  assign c_if.up = up;  assign c_if.load = ld;  assign c_if.d = d3;
    assign l_if.en = en;  assign l_if.up = up;  assign l_if.load = ld;  assign l_if.d = dl;
    assign h_if.en = l_if.tc;
    assign h_if.up = up;  assign h_if.load = ld;  assign h_if.d = dh;

    updown_counter_mod #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u_a (.clk(clk), .reset(rst_n), .bus(a_if));
    updown_counter_mod #(.WIDTH(3), .MODULO(6), .SATURATE(1'b0)) u_b (.clk(clk), .reset(rst_n), .bus(b_if));
    updown_counter_mod #(.WIDTH(3), .MODULO(8), .SATURATE(1'b1)) u_c (.clk(clk), .reset(rst_n), .bus(c_if));
    updown_counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_lo (.clk(clk), .reset(rst_n), .bus(l_if));
    updown_counter_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_hi (.clk(clk), .reset(rst_n), .bus(h_if));

    int   dq[5], dn[5];
    logic dw[5], dt[5];
    assign dq[0] = int'(a_if.Q);  assign dn[0] = int'(a_if.nQ);  assign dw[0] = a_if.wrap;  assign dt[0] = a_if.tc;
    assign dq[1] = int'(b_if.Q);  assign dn[1] = int'(b_if.nQ);  assign dw[1] = b_if.wrap;  assign dt[1] = b_if.tc;
    assign dq[2] = int'(c_if.Q);  assign dn[2] = int'(c_if.nQ);  assign dw[2] = c_if.wrap;  assign dt[2] = c_if.tc;
    assign dq[3] = int'(l_if.Q);  assign dn[3] = int'(l_if.nQ);  assign dw[3] = l_if.wrap;  assign dt[3] = l_if.tc;
    assign dq[4] = int'(h_if.Q);  assign dn[4] = int'(h_if.nQ);  assign dw[4] = h_if.wrap;  assign dt[4] = h_if.tc;

    typedef struct packed {
        logic [4:0][3:0] q;
        logic [4:0]      w;
    } exp_t;

    exp_t       expq[$];
    logic [4:0] tcq[$];

    int mods[3] = '{8, 6, 8};
    bit sats[3] = '{1'b0, 1'b0, 1'b1};
    int wd[5]   = '{3, 3, 3, 4, 4};
    int mq[3];
    int tot;  // cascade modelled as a single decimal count 0..99

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %0d, want %0d", nm, idx, $time, act, exp);
        end
    endtask

    function automatic bit tcf(input int q, input int m, input bit e, input bit u);
        return e && (u ? (q == m - 1) : (q == 0));
    endfunction

    function automatic void nxt(input int q, input int m, input bit s, input bit e, input bit u,
                                input bit l, input int dv, output int nq, output bit w);
        w  = 1'b0;
        nq = q;
        if (l) nq = (dv > m - 1) ? m - 1 : dv;
        else if (e && u) begin
            if (q == m - 1) begin nq = s ? q : 0; w = !s; end
            else nq = q + 1;
        end else if (e) begin
            if (q == 0) begin nq = s ? 0 : m - 1; w = !s; end
            else nq = q - 1;
        end
    endfunction

    task automatic cycle(input bit e, input bit u, input bit l, input int dv3, input int dlo, input int dhi);
        exp_t       x;
        logic [4:0] t;
        int         lo, hi, nq;
        bit         w;
        @(negedge clk);
        rst_n = 1'b1; en = e; up = u; ld = l;
        d3 = 3'(dv3); dl = 4'(dlo); dh = 4'(dhi);
        lo = tot % 10;
        hi = tot / 10;
        for (int i = 0; i < 3; i++) t[i] = tcf(mq[i], mods[i], e, u);
        t[3] = tcf(lo, 10, e, u);
        t[4] = t[3] && tcf(hi, 10, 1'b1, u);
        tcq.push_back(t);
        for (int i = 0; i < 3; i++) begin
            nxt(mq[i], mods[i], sats[i], e, u, l, dv3, nq, w);
            mq[i]  = nq;
            x.q[i] = 4'(nq);
            x.w[i] = w;
        end
        x.w[3] = 1'b0;
        x.w[4] = 1'b0;
        if (l) begin
            lo  = (dlo > 9) ? 9 : dlo;
            hi  = (dhi > 9) ? 9 : dhi;
            tot = hi * 10 + lo;
        end else if (e) begin
            x.w[3] = u ? (lo == 9) : (lo == 0);
            x.w[4] = x.w[3] && (u ? (hi == 9) : (hi == 0));
            tot    = (tot + (u ? 1 : 99)) % 100;
        end
        x.q[3] = 4'(tot % 10);
        x.q[4] = 4'(tot / 10);
        expq.push_back(x);
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 5; i++) begin
            chk("rst_Q", i, dq[i], 0);
            chk("rst_wrap", i, int'(dw[i]), 0);
            chk("rst_nQ", i, dn[i], (1 << wd[i]) - 1);
            chk("rst_tc", i, int'(dt[i]), int'(en & ~up));
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_state();
        for (int i = 0; i < 3; i++) mq[i] = 0;
        tot = 0;
    endtask

    initial begin : mon_state
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                for (int i = 0; i < 5; i++) begin
                    chk("Q", i, dq[i], int'(x.q[i]));
                    chk("wrap", i, int'(dw[i]), int'(x.w[i]));
                    chk("nQ", i, dn[i], ((1 << wd[i]) - 1) ^ int'(x.q[i]));
                end
            end
        end
    end

    initial begin : mon_tc
        logic [4:0] t;
        forever begin
            @(negedge clk);
            #1;
            if (tcq.size() > 0) begin
                t = tcq.pop_front();
                for (int i = 0; i < 5; i++) chk("tc", i, int'(dt[i]), int'(t[i]));
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; en = 1'b1; up = 1'b0; ld = 1'b0;
        d3 = '0; dl = '0; dh = '0;
        for (int i = 0; i < 3; i++) mq[i] = 0;
        tot = 0;
        #3 chk_reset_state();

        repeat (10) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 0);
        repeat (7) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 1'b1, 7, 15, 12);
        cycle(1'b1, 1'b1, 1'b1, 2, 3, 4);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 0);
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 0);
        repeat (25) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
        cycle(1'b0, 1'b0, 1'b1, 5, 5, 0);
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
        async_reset();
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);

        repeat (400) begin
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        end
        async_reset();
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("drain", 0, expq.size() + tcq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised synchronous up/down counter with modulo range, parallel load, count enable, saturate/wrap mode and cascade outputs. It succeeds the fixed 3-bit ripple decrement counter. All flops share one clock, so there is no ripple skew. It sits in the sequential-circuits library as the general counter primitive, and it can be chained into wider or BCD-style counters through the en/tc pair.

Parameters:
WIDTH, 3, counter width in bits (>=1)
MODULO, 8, count range is 0..MODULO-1; legal range 2 <= MODULO <= 2**WIDTH; elaboration error otherwise
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  count enable; chain input from the previous stage's tc
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load strobe
d  input  WIDTH  load value
Q  output  WIDTH  current count (registered)
nQ  output  WIDTH  bitwise complement of Q (combinational from Q)
tc  output  1  terminal count (combinational): en & ((up & Q==MODULO-1) | (~up & Q==0))
wrap  output  1  registered one-cycle pulse, set in the cycle after a wrap occurs

Behaviour:
- Reset:
  - reset low forces Q=0 and wrap=0 immediately, independent of clk.
  - Consequently nQ = all ones, and tc = en & ~up.
  - Release of reset is synchronous to the next rising clk edge; the first count update happens on that edge if en=1.
- Update priority on each rising clk edge while reset is high: load > en > hold.
- load=1:
  - Q <= d if d <= MODULO-1, else Q <= MODULO-1 (clamp).
  - wrap <= 0.
  - en and up are ignored.
- load=0, en=1, up=1:
  - Q < MODULO-1: Q <= Q+1, wrap <= 0.
  - Q == MODULO-1, SATURATE=0: Q <= 0, wrap <= 1.
  - Q == MODULO-1, SATURATE=1: Q holds, wrap <= 0.
- load=0, en=1, up=0:
  - Q > 0: Q <= Q-1, wrap <= 0.
  - Q == 0, SATURATE=0: Q <= MODULO-1, wrap <= 1.
  - Q == 0, SATURATE=1: Q holds, wrap <= 0.
- load=0, en=0: Q holds, wrap <= 0.
- Out-of-range Q is unreachable because both reset and load clamp into range. Any Q >= MODULO (for example, when forced in simulation) is treated as MODULO-1 on the next count.
- Arithmetic is WIDTH bits, unsigned. When MODULO = 2**WIDTH, the comparisons reduce to the natural overflow values.
- Latency:
  - Q changes 1 clock after load/en is sampled.
  - tc has zero latency (combinational), for cascading: a stage's en connects to the tc of the previous stage.
  - wrap asserts in the cycle after the wrapping edge, for exactly one cycle unless wrapping continues.
- Direction change takes effect on the same edge it is sampled; no pipeline.
- tc is still asserted when SATURATE=1 at a range end; downstream logic gates on it as needed.
- Reset asserted mid-count aborts immediately; no partial update is retained.

Test Plan:
- Defaults (WIDTH=3, MODULO=8): reset low, then high with en=1, up=1 for 10 clocks. Required: Q = 1,2,...,7,0,1,2; wrap high only in the cycle after Q goes 7->0; tc high whenever Q=7.
- MODULO=6, up=0, en=1 from Q=0. Required: Q = 5,4,3,2,1,0,5; wrap pulses after each 0->5; tc high at Q=0.
- MODULO=6: load=1 with d=7. Required: Q=5 next cycle. Then load=1, en=1, up=1, d=2: Q=2, since load wins over count.
- SATURATE=1, MODULO=8: count up to 7 and hold en=1 for 3 more clocks. Required: Q stays 7, wrap stays 0, tc=1. Then up=0 drives Q to 0 and it stays at 0.
- Cascade two instances (low-stage tc drives high-stage en; WIDTH=4, MODULO=10): 25 up-counts from 0. Required: high=2, low=5, with no glitch-induced extra counts.
- Assert reset asynchronously mid-clock-period at Q=5. Required: Q=0 and wrap=0 before the next edge; counting resumes from 1 on the first edge after release.
